simd_dotp_fu: RTL

- Parametrised packed-SIMD dot-product/accumulate functional unit for the CVA6 execute stage.
- Splits operand A and operand B into NUM_LANES lanes of LANE_W bits each.
- Multiplies each lane pair with per-operand signedness selected at run time, reduces the products through a pipelined adder tree, then optionally adds a 32/64-bit addend with optional saturation.
- Fully pipelined with one issue per cycle; results return in order, tagged with the instruction's trans_id.

---
 rtl/simd_dotp_pkg.sv | 29 ++
 rtl/simd_dotp_tree_level.sv | 67 ++++++
 rtl/simd_dotp_fu.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/simd_dotp_pkg.sv
// ============================================================================
// simd_dotp_pkg : op-field positions and width/latency helpers for simd_dotp_fu
// Revision      : 1.0
// ============================================================================
`default_nettype none

package simd_dotp_pkg;

  localparam int SIGN_A = 0;
  localparam int SIGN_B = 1;
  localparam int ACC    = 2;

  // Signed (LANE_W+1)x(LANE_W+1) product width
  function automatic int prod_w(input int lane_w);
    return 2 * lane_w + 2;
  endfunction

  // Input width of adder-tree level lvl (level 0 consumes raw products)
  function automatic int level_w(input int lane_w, input int lvl);
    return 2 * lane_w + 2 + lvl;
  endfunction

  function automatic int latency(input int num_lanes);
    return 2 + $clog2(num_lanes);
  endfunction

endpackage

`default_nettype wire

// File: rtl/simd_dotp_tree_level.sv
// ============================================================================
// simd_dotp_tree_level : one registered level of pairwise signed adds
// Revision             : 1.0
// ============================================================================
`default_nettype none

module simd_dotp_tree_level #(
  parameter int N_IN   = 4,
  parameter int IN_W   = 18,
  parameter int TID_W  = 4,
  parameter int SIDE_W = 33
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic                             valid_i,
  input  logic [TID_W-1:0]                 tid_i,
  input  logic [SIDE_W-1:0]                side_i,
  input  logic [N_IN*IN_W-1:0]             data_i,
  output logic                             valid_o,
  output logic [TID_W-1:0]                 tid_o,
  output logic [SIDE_W-1:0]                side_o,
  output logic [(N_IN/2)*(IN_W+1)-1:0]     data_o
);

  localparam int N_OUT = N_IN / 2;
  localparam int OUT_W = IN_W + 1;

  logic [N_OUT*OUT_W-1:0] sum_d, sum_q;
  logic                   valid_q;
  logic [TID_W-1:0]       tid_q;
  logic [SIDE_W-1:0]      side_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_OUT; i++) begin
      sum_d[i*OUT_W +: OUT_W] =
          {data_i[(2*i)*IN_W + IN_W-1],   data_i[(2*i)*IN_W   +: IN_W]}
        + {data_i[(2*i+1)*IN_W + IN_W-1], data_i[(2*i+1)*IN_W +: IN_W]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tid_q   <= '0;
      side_q  <= '0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_i & ~flush_i;
      // Data only moves with a valid op to avoid needless toggling
      if (valid_i) begin
        tid_q  <= tid_i;
        side_q <= side_i;
        sum_q  <= sum_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign tid_o   = tid_q;
  assign side_o  = side_q;
  assign data_o  = sum_q;

endmodule

`default_nettype wire

// File: rtl/simd_dotp_fu.sv
// ============================================================================
// simd_dotp_fu : pipelined packed-SIMD dot product with optional accumulate
// Revision     : 1.0
// ============================================================================
`default_nettype none

module simd_dotp_fu
  import simd_dotp_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int NUM_LANES     = 4,
  parameter int LANE_W        = 8,
  parameter int TRANS_ID_BITS = 4,
  parameter int SATURATE      = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [2:0]               op_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [XLEN-1:0]          operand_c_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o
);

  localparam int PW     = prod_w(LANE_W);
  localparam int LEVELS = $clog2(NUM_LANES);
  localparam int TW     = PW + LEVELS;
  // Wide enough for both the tree sum and the addend plus a carry
  localparam int FW     = ((XLEN > TW) ? XLEN : TW) + 2;
  localparam int SIDE_W = XLEN + 1;

  if (NUM_LANES * LANE_W != XLEN) begin : g_chk_width
    $fatal(1, "simd_dotp_fu: NUM_LANES*LANE_W must equal XLEN");
  end
  if (NUM_LANES < 2 || (NUM_LANES & (NUM_LANES - 1)) != 0) begin : g_chk_lanes
    $fatal(1, "simd_dotp_fu: NUM_LANES must be a power of two >= 2");
  end

  assign ready_o = 1'b1;

  // ---------------- S1: lane multiply ----------------
  logic signed [PW-1:0]       a_ext [NUM_LANES];
  logic signed [PW-1:0]       b_ext [NUM_LANES];
  logic [NUM_LANES*PW-1:0]    prod_d, prod_q;
  logic                       s1_valid_q;
  logic [TRANS_ID_BITS-1:0]   s1_tid_q;
  logic [SIDE_W-1:0]          s1_side_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign a_ext[i] = {{(PW-LANE_W){op_i[SIGN_A] & operand_a_i[i*LANE_W + LANE_W-1]}},
                       operand_a_i[i*LANE_W +: LANE_W]};
    assign b_ext[i] = {{(PW-LANE_W){op_i[SIGN_B] & operand_b_i[i*LANE_W + LANE_W-1]}},
                       operand_b_i[i*LANE_W +: LANE_W]};
    assign prod_d[i*PW +: PW] = a_ext[i] * b_ext[i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_tid_q   <= '0;
      s1_side_q  <= '0;
      prod_q     <= '0;
    end else begin
      s1_valid_q <= valid_i & ~flush_i;
      if (valid_i) begin
        s1_tid_q  <= trans_id_i;
        s1_side_q <= {op_i[ACC], operand_c_i};
        prod_q    <= prod_d;
      end
    end
  end

  // ---------------- adder tree ----------------
  logic [NUM_LANES*PW-1:0]  lvl_data  [LEVELS+1];
  logic                     lvl_valid [LEVELS+1];
  logic [TRANS_ID_BITS-1:0] lvl_tid   [LEVELS+1];
  logic [SIDE_W-1:0]        lvl_side  [LEVELS+1];

  assign lvl_data[0]  = prod_q;
  assign lvl_valid[0] = s1_valid_q;
  assign lvl_tid[0]   = s1_tid_q;
  assign lvl_side[0]  = s1_side_q;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NIN = NUM_LANES >> l;
    localparam int IW  = level_w(LANE_W, l);
    logic [(NIN/2)*(IW+1)-1:0] dout;

    simd_dotp_tree_level #(
      .N_IN   (NIN),
      .IN_W   (IW),
      .TID_W  (TRANS_ID_BITS),
      .SIDE_W (SIDE_W)
    ) u_level (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .valid_i (lvl_valid[l]),
      .tid_i   (lvl_tid[l]),
      .side_i  (lvl_side[l]),
      .data_i  (lvl_data[l][NIN*IW-1:0]),
      .valid_o (lvl_valid[l+1]),
      .tid_o   (lvl_tid[l+1]),
      .side_o  (lvl_side[l+1]),
      .data_o  (dout)
    );

    assign lvl_data[l+1] = (NUM_LANES*PW)'(dout);
  end

  // ---------------- final: accumulate and clamp ----------------
  logic [TW-1:0]            tree_sum;
  logic [FW-1:0]            sum_ext, c_ext, total;
  logic [XLEN-1:0]          res_d, res_q;
  logic                     out_valid_q;
  logic [TRANS_ID_BITS-1:0] out_tid_q;

  assign tree_sum = lvl_data[LEVELS][TW-1:0];
  assign sum_ext  = {{(FW-TW){tree_sum[TW-1]}}, tree_sum};
  assign c_ext    = lvl_side[LEVELS][XLEN]
                  ? {{(FW-XLEN){lvl_side[LEVELS][XLEN-1]}}, lvl_side[LEVELS][XLEN-1:0]}
                  : '0;
  assign total    = sum_ext + c_ext;

  if (SATURATE != 0) begin : g_sat
    logic ovf;
    // Out of range when the bits above the XLEN sign bit disagree with it
    assign ovf   = total[FW-1:XLEN-1] != {(FW-XLEN+1){total[FW-1]}};
    assign res_d = !ovf          ? total[XLEN-1:0]
                 : total[FW-1]   ? {1'b1, {(XLEN-1){1'b0}}}
                 :                 {1'b0, {(XLEN-1){1'b1}}};
  end else begin : g_wrap
    assign res_d = total[XLEN-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_tid_q   <= '0;
      res_q       <= '0;
    end else begin
      out_valid_q <= lvl_valid[LEVELS] & ~flush_i;
      if (lvl_valid[LEVELS]) begin
        out_tid_q <= lvl_tid[LEVELS];
        res_q     <= res_d;
      end
    end
  end

  assign valid_o    = out_valid_q;
  assign result_o   = out_valid_q ? res_q : '0;
  assign trans_id_o = out_valid_q ? out_tid_q : '0;

endmodule

`default_nettype wire
